dpll_ref_gen: RTL and testbench
===============================

# dpll_ref_gen

Programmable reference-signal generator that drives the `signal_in` side of the team's digital PLL. It emits a square wave whose half-period, in `clk` cycles, is set at run time. It also injects single-shot phase steps, so loop pull-in, lock detection (`syn`) and tracking can be exercised from a bench or on-chip self-test. Configuration arrives over a one-deep valid/ready command port.

## Interface
- `W`, 9: width of half-period registers and counter.
- `STEPW`, 8: width of signed phase-step field.
- `DEF_HALF`, 64: half-period after reset (64 gives a 128-cycle period, the PLL nominal with K=4, N=16, /8 prescale).

- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-low.
- `cfg_valid` in 1: command valid.
- `cfg_ready` out 1: command slot free.
- `cfg_op` in 2: 00 set half-period, 01 phase step, 10 enable, 11 disable.
- `cfg_half` in W: new half-period (op 00).
- `cfg_step` in STEPW: signed two's-complement step in cycles (op 01).
- `signal_out` out 1: generated reference, registered.
- `edge_strobe` out 1: one-cycle pulse coincident with every `signal_out` change.
- `busy` out 1: high when state is not IDLE.
- `rise_cnt` out 16: count of rising edges of `signal_out`; wraps at 0xFFFF to 0.

## Operation
- Reset values: `signal_out`=0, `edge_strobe`=0, `cfg_ready`=1, `busy`=0, `rise_cnt`=0.
- Internal reset values: state IDLE, `cnt`=0, `half_act`=DEF_HALF, `len`=DEF_HALF, pending slot empty.
- Command handshake:
  - A command is accepted on a posedge with `cfg_valid && cfg_ready`.
  - The accepted command is latched into the single pending slot.
  - `cfg_ready` = slot empty, registered. It drops the cycle after acceptance.
  - `cfg_ready` is low for at least one cycle per command, so back-to-back commands stall.
- Consumption rules:
  - In IDLE, any pending op is consumed on the next posedge:
    - 00: loads `half_act`.
    - 01: discarded.
    - 10: moves to RUN with `cnt`=0 and `len`=clamp(`half_act`).
    - 11: no-op.
  - In RUN or DRAIN:
    - 10 and 11 are consumed on the next posedge. 11 goes to DRAIN; 10 is a no-op.
    - 00 and 01 are consumed only at the next toggle.
- State machine IDLE / RUN / DRAIN:
  - IDLE: `signal_out` held 0, `cnt` held 0.
  - RUN:
    - `cnt` increments each cycle.
    - When `cnt`==`len`-1: `signal_out` toggles, `edge_strobe`=1, `cnt`←0.
    - `len` for the next half-phase = clamp(H + S), where:
      - H = pending `cfg_half` if op 00 is pending, else `half_act`.
      - S = pending step if op 01 is pending, else 0.
    - `half_act`←H. A step affects exactly one half-phase.
  - DRAIN:
    - If `signal_out`=0, go to IDLE on the next posedge.
    - Otherwise keep counting, and go to IDLE on the falling toggle. The final high phase completes at full length.
- Arithmetic:
  - H + S is computed signed in W+2 bits.
  - clamp(x) = 1 if x<1, 2^W−1 if x>2^W−1, else x.
  - `cfg_half`=0 is therefore treated as 1.
- `rise_cnt` increments in the same cycle as every 0→1 toggle.
- Asynchronous reset mid-operation returns all outputs and internal state to their reset values immediately. A pending command is lost.

## Timing
- Enable accepted at posedge T: state RUN at T+1.
- First rising edge of `signal_out` is registered at posedge T+`len`, and `edge_strobe` is high in that cycle.
- Steady state: each half-phase lasts exactly `len` cycles. Period = 2·`half_act` with no step pending.
- Period/step latency: takes effect on the half-phase that starts at the first toggle after acceptance.
  - If acceptance and a toggle fall on the same posedge, the command applies at the following toggle.
- Simultaneous toggle and consumption: `cfg_ready` rises one cycle after the consuming posedge.
- `busy` drops in the same cycle as the state enters IDLE.

## Test plan
- Enable after reset (defaults):
  - `signal_out` first rises 64 cycles after enable acceptance.
  - Period is 128 cycles and `rise_cnt` = 1, 2, 3… on successive rising edges.
  - `edge_strobe` is 1 cycle wide on both edges.
- Period change, half=64 → 10:
  - Command accepted mid-high-phase.
  - The current phase finishes its 64 cycles; all later half-phases are 10 cycles.
  - `cfg_ready` is low from acceptance until one cycle after that toggle.
- Phase step −5 at half=64: exactly one half-phase of 59 cycles, then 64 thereafter. Step +7 gives one 71-cycle phase.
- Clamps:
  - half=64, step −100 → one 1-cycle phase.
  - half=500, step +100 → one 511-cycle phase.
  - `cfg_half`=0 → 1-cycle half-phases, so `signal_out` toggles every clock.
- Back-to-back commands: second `cfg_valid` held during the pending step; it stalls until the step is consumed, then is accepted on the next ready cycle. No command is lost or duplicated.
- Disable and reset:
  - Disable while high: output stays high for the remainder of the phase, then falls, then `busy`=0.
  - Disable while low: IDLE next cycle.
  - `reset` low mid-RUN: all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/dpll_ref_gen.sv
// Square-wave reference for the DPLL with run-time half-period and one-shot phase steps; signal_out registered, first rise len cycles after enable acceptance.
// One-deep command slot: cfg_ready drops on acceptance and returns one cycle after the slot is consumed, so back-to-back commands stall.
module dpll_ref_gen #(
    parameter int W        = 9,
    parameter int STEPW    = 8,
    parameter int DEF_HALF = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_op,
    input  logic [W-1:0]     cfg_half,
    input  logic [STEPW-1:0] cfg_step,
    output logic             signal_out,
    output logic             edge_strobe,
    output logic             busy,
    output logic [15:0]      rise_cnt
);
    localparam int SW = W + 2;
    localparam logic signed [SW-1:0] ONE_S = SW'(1);
    localparam logic signed [SW-1:0] MAX_S = SW'((1 << W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state, state_nxt;
    logic [W-1:0]             cnt, len, half_act;
    logic                     pend_vld;
    logic [1:0]               pend_op;
    logic [W-1:0]             pend_half;
    logic signed [STEPW-1:0]  pend_step;

    logic                     accept, hit, toggle, consume, enter;
    logic                     p_half, p_step, p_ctrl;
    logic [W-1:0]             h_sel, len_next, len_idle;
    logic signed [STEPW-1:0]  s_sel;
    logic signed [SW-1:0]     sum;

    always_comb begin
        accept   = cfg_valid && cfg_ready;
        p_half   = pend_vld && (pend_op == 2'b00);
        p_step   = pend_vld && (pend_op == 2'b01);
        p_ctrl   = pend_vld && pend_op[1];
        hit      = (cnt == len - W'(1));
        h_sel    = p_half ? pend_half : half_act;
        s_sel    = p_step ? pend_step : '0;
        sum      = $signed({2'b00, h_sel}) + SW'(s_sel);
        if (sum < ONE_S)
            len_next = W'(1);
        else if (sum > MAX_S)
            len_next = {W{1'b1}};
        else
            len_next = sum[W-1:0];
        len_idle  = (half_act == '0) ? W'(1) : half_act;
        toggle    = 1'b0;
        consume   = 1'b0;
        enter     = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                consume = pend_vld;
                if (pend_vld && pend_op == 2'b10) begin
                    state_nxt = RUN;
                    enter     = 1'b1;
                end
            end
            RUN: begin
                toggle  = hit;
                consume = p_ctrl || (hit && pend_vld);
                if (pend_vld && pend_op == 2'b11)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // a high phase always completes at full length before stopping
                if (!signal_out) begin
                    consume   = p_ctrl;
                    state_nxt = IDLE;
                end else begin
                    toggle  = hit;
                    consume = p_ctrl || (hit && pend_vld);
                    if (hit)
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            len         <= W'(DEF_HALF);
            half_act    <= W'(DEF_HALF);
            pend_vld    <= 1'b0;
            pend_op     <= 2'b00;
            pend_half   <= '0;
            pend_step   <= '0;
            cfg_ready   <= 1'b1;
            signal_out  <= 1'b0;
            edge_strobe <= 1'b0;
            busy        <= 1'b0;
            rise_cnt    <= '0;
        end else begin
            edge_strobe <= 1'b0;
            state       <= state_nxt;
            busy        <= (state_nxt != IDLE);
            cfg_ready   <= !pend_vld && !accept;
            if (consume)
                pend_vld <= 1'b0;
            if (accept) begin
                pend_vld  <= 1'b1;
                pend_op   <= cfg_op;
                pend_half <= cfg_half;
                pend_step <= cfg_step;
            end
            if (state == IDLE) begin
                if (p_half)
                    half_act <= pend_half;
                // the consuming edge counts as the first cycle of the opening phase
                if (enter) begin
                    len <= len_idle;
                    if (len_idle == W'(1)) begin
                        signal_out  <= 1'b1;
                        edge_strobe <= 1'b1;
                        rise_cnt    <= rise_cnt + 16'd1;
                        cnt         <= '0;
                    end else begin
                        cnt <= W'(1);
                    end
                end
            end else if (toggle) begin
                signal_out  <= !signal_out;
                edge_strobe <= 1'b1;
                cnt         <= '0;
                len         <= len_next;
                half_act    <= h_sel;
                if (!signal_out)
                    rise_cnt <= rise_cnt + 16'd1;
            end else if (state_nxt == IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dpll_ref_gen.sv
// Bench for dpll_ref_gen: toggle times are recorded by a passive monitor and compared with
// half-phase lengths predicted from the command history (clamp(half + one-shot step)).
module tb_dpll_ref_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_op = 2'b00;
    logic [8:0]  cfg_half = '0;
    logic [7:0]  cfg_step = '0;
    logic        signal_out, edge_strobe, busy;
    logic [15:0] rise_cnt;

    dpll_ref_gen #(.W(9), .STEPW(8), .DEF_HALF(64)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_op(cfg_op), .cfg_half(cfg_half), .cfg_step(cfg_step),
        .signal_out(signal_out), .edge_strobe(edge_strobe), .busy(busy), .rise_cnt(rise_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // passive toggle recorder
    int          ev_t [0:4095];
    logic        ev_lvl [0:4095];
    logic [15:0] ev_rc [0:4095];
    int          wr_idx = 0;
    int          strobe_bad = 0;
    logic        mon_lvl = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            mon_lvl <= 1'b0;
        end else begin
            if (edge_strobe !== (signal_out !== mon_lvl))
                strobe_bad <= strobe_bad + 1;
            if (signal_out !== mon_lvl && wr_idx < 4096) begin
                ev_t[wr_idx]   <= cyc;
                ev_lvl[wr_idx] <= signal_out;
                ev_rc[wr_idx]  <= rise_cnt;
                wr_idx         <= wr_idx + 1;
                mon_lvl        <= signal_out;
            end
        end
    end

    typedef struct {int t; bit is_half; int val;} cmd_t;
    cmd_t        cmdq[$];
    int          rd_idx = 0;
    int          checks = 0;
    int          errors = 0;
    int          last_t = 0;
    int          m_half = 64;
    logic        m_lvl = 1'b0;
    logic [15:0] m_rise = '0;

    function automatic int clamp(input int x);
        if (x < 1) return 1;
        if (x > 511) return 511;
        return x;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // commands accepted strictly before a toggle shape the half-phase that starts there
    task automatic model_phase(input int tp, output int len);
        int s = 0;
        while (cmdq.size() > 0 && cmdq[0].t < tp) begin
            if (cmdq[0].is_half) m_half = cmdq[0].val;
            else s += cmdq[0].val;
            cmdq.delete(0);
        end
        len = clamp(m_half + s);
    endtask

    task automatic send(input logic [1:0] op, input int val, output int ta);
        ta        = -1;
        cfg_op    = op;
        cfg_half  = 9'(val);
        cfg_step  = 8'(val);
        cfg_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            if (cfg_ready) begin
                @(posedge clk);
                #1;
                ta = cyc;
                break;
            end
            tick();
        end
        tick();
        cfg_valid = 1'b0;
        if (ta < 0) begin
            checks++; errors++;
            $display("FAIL cmd_accept op=%0d never accepted within 2000 cycles", op);
        end else if (op == 2'b00 || op == 2'b01) begin
            cmdq.push_back('{ta, (op == 2'b00), val});
        end
    endtask

    task automatic get_edge(output int t, output logic lv, output logic [15:0] rc);
        t = -1; lv = 1'b0; rc = '0;
        for (int n = 0; n < 1500; n++) begin
            if (rd_idx < wr_idx) begin
                t = ev_t[rd_idx]; lv = ev_lvl[rd_idx]; rc = ev_rc[rd_idx];
                rd_idx++;
                break;
            end
            tick();
        end
        if (t < 0) begin
            checks++; errors++;
            $display("FAIL edge_timeout no toggle of signal_out within 1500 cycles");
        end
    endtask

    task automatic check_run(input int n, input string name);
        int t, exp_len;
        logic lv;
        logic [15:0] rc;
        for (int k = 0; k < n; k++) begin
            get_edge(t, lv, rc);
            if (t < 0) return;
            model_phase(last_t, exp_len);
            m_lvl = !m_lvl;
            checks++;
            if ((t - last_t) !== exp_len || lv !== m_lvl) begin
                errors++;
                $display("FAIL %s phase %0d: len=%0d level=%0b, expected len=%0d level=%0b",
                         name, k, t - last_t, lv, exp_len, m_lvl);
            end
            if (m_lvl) begin
                m_rise = m_rise + 16'd1;
                checks++;
                if (rc !== m_rise) begin
                    errors++;
                    $display("FAIL %s rise_cnt: got %0d, expected %0d", name, rc, m_rise);
                end
            end
            last_t = t;
        end
    endtask

    task automatic wait_high();
        for (int i = 0; i < 4 && m_lvl !== 1'b1; i++) check_run(1, "wait_high");
    endtask

    task automatic start_run(input string name);
        int ta, t;
        logic lv;
        logic [15:0] rc;
        send(2'b10, 0, ta);
        get_edge(t, lv, rc);
        if (t < 0) return;
        m_rise = m_rise + 16'd1;
        checks++;
        if ((t - ta) !== clamp(m_half) || lv !== 1'b1 || rc !== m_rise) begin
            errors++;
            $display("FAIL %s first rise: delay=%0d level=%0b rise_cnt=%0d, expected delay=%0d level=1 rise_cnt=%0d",
                     name, t - ta, lv, rc, clamp(m_half), m_rise);
        end
        last_t = t;
        m_lvl  = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #2;
        checks++;
        if ({signal_out, edge_strobe, cfg_ready, busy, rise_cnt} !== {4'b0010, 16'h0}) begin
            errors++;
            $display("FAIL reset_state: out=%0b strobe=%0b ready=%0b busy=%0b rise=%0d, expected 0 0 1 0 0",
                     signal_out, edge_strobe, cfg_ready, busy, rise_cnt);
        end
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_enable();
        start_run("enable");
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL enable_busy: got %0b, expected 1", busy); end
        check_run(6, "enable_default");
        checks++;
        if (strobe_bad !== 0) begin errors++; $display("FAIL edge_strobe_enable: %0d bad cycles, expected 0", strobe_bad); end
    endtask

    task automatic test_period_change();
        int ta, n;
        wait_high();
        repeat (20) tick();
        send(2'b00, 10, ta);
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_after_accept: got %0b, expected 0", cfg_ready); end
        n = 0;
        while (rd_idx == wr_idx && n < 200) begin tick(); n++; end
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_at_toggle: got %0b, expected 0", cfg_ready); end
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after_toggle: got %0b, expected 1", cfg_ready); end
        check_run(5, "period_64_to_10");
        send(2'b00, 64, ta);
        check_run(3, "period_back_64");
    endtask

    task automatic test_steps_clamps();
        logic [1:0] t_op [8]  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00};
        int         t_val [8] = '{64, -5, 7, -100, 500, 100, 0, 64};
        int         t_n [8]   = '{3, 3, 3, 3, 2, 3, 8, 3};
        int ta;
        for (int i = 0; i < 8; i++) begin
            send(t_op[i], t_val[i], ta);
            check_run(t_n[i], $sformatf("table_%0d_op%0d_val%0d", i, t_op[i], t_val[i]));
        end
        checks++;
        if (strobe_bad !== 0) begin errors++; $display("FAIL edge_strobe_clamps: %0d bad cycles, expected 0", strobe_bad); end
    endtask

    task automatic test_random();
        int ta, val;
        logic [1:0] op;
        for (int i = 0; i < 8; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01;
            if (op == 2'b00) val = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 100));
            else val = int'($urandom_range(0, 255)) - 128;
            send(op, val, ta);
            check_run(3, $sformatf("random_%0d_op%0d_val%0d", i, op, val));
        end
        send(2'b00, 64, ta);
        check_run(3, "random_restore");
    endtask

    task automatic test_back_to_back();
        int ta1, ta2, tc, s1, h2;
        s1 = int'($urandom_range(0, 40)) - 20;
        h2 = int'($urandom_range(20, 60));
        send(2'b01, s1, ta1);
        send(2'b00, h2, ta2);
        tc = -1;
        for (int i = rd_idx; i < wr_idx; i++) begin
            if (ev_t[i] > ta1) begin tc = ev_t[i]; break; end
        end
        checks++;
        if (ta2 !== tc + 2) begin
            errors++;
            $display("FAIL b2b_accept_time: second accepted at %0d, expected %0d", ta2, tc + 2);
        end
        check_run(5, "back_to_back");
    endtask

    task automatic test_disable();
        int ta, t, exp_len;
        logic lv;
        logic [15:0] rc;
        wait_high();
        repeat (5) tick();
        send(2'b11, 0, ta);
        checks++;
        if (busy !== 1'b1 || signal_out !== 1'b1) begin
            errors++;
            $display("FAIL disable_high_hold: busy=%0b out=%0b, expected 1 1", busy, signal_out);
        end
        get_edge(t, lv, rc);
        model_phase(last_t, exp_len);
        checks++;
        if ((t - last_t) !== exp_len || lv !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL disable_high_fall: len=%0d level=%0b busy=%0b, expected len=%0d level=0 busy=0",
                     t - last_t, lv, busy, exp_len);
        end
        m_lvl = 1'b0;
        repeat (150) tick();
        checks++;
        if (wr_idx !== rd_idx || busy !== 1'b0) begin
            errors++;
            $display("FAIL disable_high_idle: extra toggles=%0d busy=%0b, expected 0 0", wr_idx - rd_idx, busy);
        end
        start_run("reenable");
        check_run(1, "disable_low_fall");
        send(2'b11, 0, ta);
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || signal_out !== 1'b0 || cyc !== ta + 2) begin
            errors++;
            $display("FAIL disable_low_idle: busy=%0b out=%0b at cycle %0d, expected 0 0 at %0d",
                     busy, signal_out, cyc, ta + 2);
        end
        repeat (100) tick();
        checks++;
        if (wr_idx !== rd_idx) begin errors++; $display("FAIL disable_low_quiet: %0d toggles, expected 0", wr_idx - rd_idx); end
    endtask

    task automatic test_reset_mid_run();
        int ta;
        start_run("pre_reset");
        send(2'b00, 20, ta);
        check_run(3, "pre_reset_half20");
        wait_high();
        send(2'b01, 5, ta);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({signal_out, edge_strobe, cfg_ready, busy, rise_cnt} !== {4'b0010, 16'h0}) begin
            errors++;
            $display("FAIL reset_mid_run: out=%0b strobe=%0b ready=%0b busy=%0b rise=%0d, expected 0 0 1 0 0",
                     signal_out, edge_strobe, cfg_ready, busy, rise_cnt);
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        rd_idx = wr_idx;
        cmdq.delete();
        m_half = 64;
        m_rise = '0;
        m_lvl  = 1'b0;
        start_run("post_reset");
        check_run(3, "post_reset_default");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_enable();
        test_period_change();
        test_steps_clamps();
        test_random();
        test_back_to_back();
        test_disable();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
